// File: rtl/wb_uart_pkg.sv
// ==========================================================================
// wb_uart_pkg : register map, STATUS bit positions and FSM encodings. Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

package wb_uart_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DIV    = 2'd2,
    REG_CTRL   = 2'd3
  } reg_idx_t;

  localparam int ST_TX_READY  = 0;
  localparam int ST_TX_BUSY   = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_uart_fifo.sv
// ==========================================================================
// wb_uart_fifo : 8-bit synchronous FIFO, power-of-two depth. Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module wb_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty when the index bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/wb_uart.sv
// ==========================================================================
// wb_uart : zero-wait-state Wishbone 8N1 UART with RX FIFO and irq. Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module wb_uart
  import wb_uart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd26,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:1]  wb_adr,
  input  logic [15:0] wb_dat_m,
  output logic [15:0] wb_dat_s,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  reg_idx_t    sel;
  logic        bus_wr, bus_rd;
  logic        wr_data, wr_div, wr_ctrl, rd_data, rd_status;
  logic [15:0] div_q;
  logic [1:0]  ctrl_q;
  logic        hold_full;
  logic [7:0]  hold_data;
  logic        overrun, frame_err;
  logic        tx_ready, tx_busy, rx_valid, rx_full;
  logic [15:0] status;
  logic [15:0] tick_cnt;
  logic        tick;

  assign wb_ack    = wb_cyc & wb_stb;
  assign sel       = reg_idx_t'(wb_adr);
  assign bus_wr    = wb_ack & wb_we;
  assign bus_rd    = wb_ack & ~wb_we;
  assign wr_data   = bus_wr && (sel == REG_DATA) && tx_ready;
  assign wr_div    = bus_wr && (sel == REG_DIV);
  assign wr_ctrl   = bus_wr && (sel == REG_CTRL);
  assign rd_data   = bus_rd && (sel == REG_DATA);
  assign rd_status = bus_rd && (sel == REG_STATUS);

  assign tick = (tick_cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tick_cnt <= '0;
    else if (wr_div || tick) tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 16'd1;
  end

  // ---------------- transmitter ----------------
  tx_state_t  tx_state, tx_state_n;
  logic [3:0] tx_sub, tx_sub_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic       txd_n;
  logic       tx_load;

  assign tx_ready = ~hold_full;
  assign tx_busy  = (tx_state != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_sub   <= tx_sub_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      txd      <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_sub_n   = tx_sub;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    txd_n      = txd;
    tx_load    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (hold_full) begin
          tx_load    = 1'b1;
          tx_sh_n    = hold_data;
          tx_sub_n   = '0;
          txd_n      = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_sub == TICK_LAST) begin
            tx_sub_n   = '0;
            tx_bit_n   = '0;
            txd_n      = tx_sh[0];
            tx_state_n = TX_DATA;
          end else begin
            tx_sub_n = tx_sub + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_sub == TICK_LAST) begin
            tx_sub_n = '0;
            if (tx_bit == 3'd7) begin
              txd_n      = 1'b1;
              tx_state_n = TX_STOP;
            end else begin
              tx_bit_n = tx_bit + 3'd1;
              tx_sh_n  = {1'b0, tx_sh[7:1]};
              txd_n    = tx_sh[1];
            end
          end else begin
            tx_sub_n = tx_sub + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_sub == TICK_LAST) begin
            tx_sub_n = '0;
            // A refilled holding register chains straight into the next start bit.
            if (hold_full) begin
              tx_load    = 1'b1;
              tx_sh_n    = hold_data;
              txd_n      = 1'b0;
              tx_state_n = TX_START;
            end else begin
              tx_state_n = TX_IDLE;
            end
          end else begin
            tx_sub_n = tx_sub + 4'd1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t  rx_state, rx_state_n;
  logic [1:0] rx_sync;
  logic       rxs;
  logic [3:0] rx_sub, rx_sub_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic       rx_push, rx_ovr_set, rx_fe_set;
  logic [7:0] fifo_dout;
  logic       fifo_empty;

  assign rxs      = rx_sync[1];
  assign rx_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_sub   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_state <= rx_state_n;
      rx_sub   <= rx_sub_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_sub_n   = rx_sub;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    rx_fe_set  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rxs) begin
          rx_sub_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_sub == TICK_MID) begin
            rx_sub_n   = '0;
            rx_bit_n   = '0;
            rx_state_n = rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_sub_n = rx_sub + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_sub == TICK_LAST) begin
            rx_sub_n = '0;
            rx_sh_n  = {rxs, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            else                rx_bit_n   = rx_bit + 3'd1;
          end else begin
            rx_sub_n = rx_sub + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_sub == TICK_LAST) begin
            rx_sub_n   = '0;
            rx_state_n = RX_IDLE;
            if (!rxs)        rx_fe_set  = 1'b1;
            else if (rx_full) rx_ovr_set = 1'b1;
            else             rx_push    = 1'b1;
          end else begin
            rx_sub_n = rx_sub + 4'd1;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  wb_uart_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rd_data),
    .din   (rx_sh),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (rx_full)
  );

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= DIV_RESET;
      ctrl_q    <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_div)  div_q  <= wb_dat_m;
      if (wr_ctrl) ctrl_q <= wb_dat_m[1:0];
      if (wr_data) begin
        hold_data <= wb_dat_m[7:0];
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
      // A new error in the same cycle as a STATUS read must survive the clear.
      overrun   <= rx_ovr_set | (overrun & ~rd_status);
      frame_err <= rx_fe_set | (frame_err & ~rd_status);
      irq       <= (ctrl_q[0] & tx_ready) | (ctrl_q[1] & rx_valid);
    end
  end

  always_comb begin
    status               = '0;
    status[ST_TX_READY]  = tx_ready;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_RX_VALID]  = rx_valid;
    status[ST_RX_FULL]   = rx_full;
    status[ST_OVERRUN]   = overrun;
    status[ST_FRAME_ERR] = frame_err;
  end

  always_comb begin
    wb_dat_s = '0;
    case (sel)
      REG_DATA:   wb_dat_s = {8'h00, (rx_valid ? fifo_dout : 8'h00)};
      REG_STATUS: wb_dat_s = status;
      REG_DIV:    wb_dat_s = div_q;
      REG_CTRL:   wb_dat_s = {14'd0, ctrl_q};
      default:    wb_dat_s = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_uart.sv
// ==========================================================================
// tb_wb_uart : scoreboard bench for wb_uart (bus reads and TX frames). Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_uart;

  logic        clk;
  logic        rst_n;
  logic [2:1]  wb_adr;
  logic [15:0] wb_dat_m;
  logic [15:0] wb_dat_s;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;
  logic        txd;
  logic        rxd;
  logic        irq;
  logic        loop_en;
  logic        rx_drv;

  int          n_vec;
  int          n_miss;
  int unsigned cyc_cnt;
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  int unsigned starts[$];
  bit          mon_busy;
  bit          rst_seen;
  logic [7:0]  tx_d;
  logic        tx_s0;
  logic        tx_s1;

  assign rxd = loop_en ? txd : rx_drv;

  wb_uart #(
    .DIV_RESET (16'd26),
    .RX_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_adr   (wb_adr),
    .wb_dat_m (wb_dat_m),
    .wb_dat_s (wb_dat_s),
    .wb_we    (wb_we),
    .wb_stb   (wb_stb),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack),
    .txd      (txd),
    .rxd      (rxd),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read monitor: every read ack cycle consumes one expected value.
  always @(negedge clk) begin
    if (rst_n && wb_cyc && wb_stb && !wb_we) begin
      check("wb_ack", {15'd0, wb_ack}, 16'd1);
      if (exp_rd.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL rd_unexpected: got %h, expected no read", wb_dat_s);
      end else begin
        check("wb_read", wb_dat_s, exp_rd.pop_front());
      end
    end
  end

  always @(negedge rst_n) rst_seen = 1'b1;

  // TX monitor: decodes frames at mid-bit, assuming DIV=0 (16 clocks per bit).
  always begin
    @(negedge clk);
    if (rst_n && !txd) begin
      mon_busy = 1'b1;
      rst_seen = 1'b0;
      starts.push_back(cyc_cnt);
      repeat (8) @(negedge clk);
      tx_s0 = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        tx_d[i] = txd;
      end
      repeat (16) @(negedge clk);
      tx_s1 = txd;
      if (!rst_seen) begin
        if (exp_tx.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL tx_unexpected: got frame %h, expected none", tx_d);
        end else begin
          check("tx_start_bit", {15'd0, tx_s0}, 16'd0);
          check("tx_byte", {8'd0, tx_d}, {8'd0, exp_tx.pop_front()});
          check("tx_stop_bit", {15'd0, tx_s1}, 16'd1);
        end
      end
      mon_busy = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_rd(input logic [1:0] idx, input logic [15:0] exp);
    exp_rd.push_back(exp);
    wb_adr = idx;
    wb_we  = 1'b0;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] idx, input logic [15:0] data);
    wb_adr   = idx;
    wb_dat_m = data;
    wb_we    = 1'b1;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || mon_busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_vec++;
    if (n >= budget) begin
      n_miss++;
      $display("FAIL tx_timeout: got %0d frames pending, expected 0", exp_tx.size());
    end
  endtask

  // Serial frame into rxd at 16 clocks per bit; a bad stop bit is held low for 12.
  task automatic send_rx(input logic [7:0] b, input logic stop_ok);
    rx_drv = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      idle(16);
    end
    if (stop_ok) begin
      rx_drv = 1'b1;
      idle(16);
    end else begin
      rx_drv = 1'b0;
      idle(12);
      rx_drv = 1'b1;
      idle(4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ovr_bytes [5];
    ovr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    n_vec    = 0;
    n_miss   = 0;
    cyc_cnt  = 0;
    mon_busy = 1'b0;
    rst_seen = 1'b0;
    rst_n    = 1'b0;
    wb_adr   = '0;
    wb_dat_m = '0;
    wb_we    = 1'b0;
    wb_stb   = 1'b0;
    wb_cyc   = 1'b0;
    loop_en  = 1'b0;
    rx_drv   = 1'b1;

    // Reset values
    repeat (5) @(posedge clk);
    #1;
    check("rst_txd_held", {15'd0, txd}, 16'd1);
    rst_n = 1'b1;
    idle(2);
    check("rst_txd", {15'd0, txd}, 16'd1);
    check("rst_irq", {15'd0, irq}, 16'd0);
    wb_rd(2'd1, 16'h0001);
    wb_rd(2'd2, 16'd26);
    wb_rd(2'd3, 16'h0000);
    wb_rd(2'd0, 16'h0000);

    wb_wr(2'd2, 16'h0000);
    wb_rd(2'd2, 16'h0000);

    // Single byte: holding register empties one clock after the write
    exp_tx.push_back(8'hA5);
    wb_wr(2'd0, 16'h00A5);
    wb_rd(2'd1, 16'h0000);
    wb_rd(2'd1, 16'h0003);
    wait_tx_idle(400);
    idle(10);
    wb_rd(2'd1, 16'h0001);

    // Back-to-back frames, third write dropped while holding register full
    starts.delete();
    exp_tx.push_back(8'h55);
    exp_tx.push_back(8'h0F);
    wb_wr(2'd0, 16'h0055);
    wb_rd(2'd1, 16'h0000);
    wb_wr(2'd0, 16'h000F);
    wb_wr(2'd0, 16'h0033);
    wb_rd(2'd1, 16'h0002);
    wait_tx_idle(600);
    idle(180);
    check("b2b_frames", 16'(starts.size()), 16'd2);
    if (starts.size() == 2) check("b2b_gap", 16'(starts[1] - starts[0]), 16'd160);
    wb_rd(2'd1, 16'h0001);

    // Loopback
    loop_en = 1'b1;
    exp_tx.push_back(8'h3C);
    wb_wr(2'd0, 16'h003C);
    wait_tx_idle(400);
    idle(20);
    wb_rd(2'd1, 16'h0005);
    wb_rd(2'd0, 16'h003C);
    wb_rd(2'd1, 16'h0001);
    loop_en = 1'b0;

    // Overrun: five frames into a four-deep FIFO
    foreach (ovr_bytes[i]) send_rx(ovr_bytes[i], 1'b1);
    idle(5);
    wb_rd(2'd1, 16'h001D);
    wb_rd(2'd1, 16'h000D);
    foreach (ovr_bytes[i]) if (i < 4) wb_rd(2'd0, {8'h00, ovr_bytes[i]});
    wb_rd(2'd1, 16'h0001);
    wb_rd(2'd0, 16'h0000);

    // Frame error, then rx interrupt
    send_rx(8'h99, 1'b0);
    idle(30);
    wb_rd(2'd1, 16'h0021);
    wb_rd(2'd1, 16'h0001);
    wb_wr(2'd3, 16'h0002);
    wb_rd(2'd3, 16'h0002);
    idle(2);
    check("irq_rx_idle", {15'd0, irq}, 16'd0);
    send_rx(8'h5A, 1'b1);
    idle(5);
    check("irq_rx_set", {15'd0, irq}, 16'd1);
    wb_rd(2'd0, 16'h005A);
    idle(2);
    check("irq_rx_clear", {15'd0, irq}, 16'd0);

    // tx interrupt
    wb_wr(2'd3, 16'h0001);
    idle(2);
    check("irq_tx_set", {15'd0, irq}, 16'd1);
    wb_wr(2'd3, 16'h0000);
    idle(2);
    check("irq_tx_clear", {15'd0, irq}, 16'd0);

    // Reset in mid-frame: txd must return high without a clock edge
    loop_en = 1'b1;
    wb_wr(2'd0, 16'h00F0);
    idle(40);
    check("pre_reset_txd", {15'd0, txd}, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_txd", {15'd0, txd}, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    loop_en = 1'b0;
    rst_n   = 1'b1;
    idle(2);
    wb_rd(2'd1, 16'h0001);
    wb_rd(2'd2, 16'd26);
    wb_rd(2'd3, 16'h0000);
    idle(50);
    wb_rd(2'd1, 16'h0001);

    idle(2);
    check("reads_pending", 16'(exp_rd.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
